// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: FSM state encoding and default parameters.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  localparam int unsigned  PC_DEF_ADDR_W      = 64;
  localparam int unsigned  PC_DEF_INSTR_BYTES = 4;
  localparam logic [63:0]  PC_DEF_RESET_VEC   = 64'h0;
  localparam int unsigned  PC_DEF_RAS_DEPTH   = 4;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-side bundle of the PC unit. The call/ret/ras_empty signals only exist when PC_RAS_EN is defined.
interface pc_unit_if import pc_pkg::*; #(
  parameter int unsigned ADDR_W = PC_DEF_ADDR_W
);

  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_addr_i;
  logic              fetch_ready_i;
  logic              halt_i;
  logic              resume_i;
  logic [ADDR_W-1:0] pc_o;
  logic              pc_valid_o;
`ifdef PC_RAS_EN
  logic              call_i;
  logic              ret_i;
  logic              ras_empty_o;
`endif

  // The slave side is the PC unit itself; the master side drives control and consumes the PC.
  modport slave (
    input  redirect_i, redirect_addr_i, fetch_ready_i, halt_i, resume_i,
`ifdef PC_RAS_EN
    input  call_i, ret_i,
    output ras_empty_o,
`endif
    output pc_o, pc_valid_o
  );

  modport master (
    output redirect_i, redirect_addr_i, fetch_ready_i, halt_i, resume_i,
`ifdef PC_RAS_EN
    output call_i, ret_i,
    input  ras_empty_o,
`endif
    input  pc_o, pc_valid_o
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push onto a full stack overwrites the oldest entry.
// Only compiled when PC_RAS_EN is defined.
`ifdef PC_RAS_EN
module pc_ras #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] topIdx;
  logic [PTR_W-1:0] nextIdx;
  logic             doPop;

  assign topIdx  = (wr_ptr_q == '0) ? PTR_W'(DEPTH - 1) : wr_ptr_q - 1'b1;
  assign nextIdx = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign top_o   = mem_q[topIdx];
  assign doPop   = pop_i && !empty_o;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (doPop && !push_i) begin
      wr_ptr_q <= topIdx;
      count_q  <= count_q - 1'b1;
    end else if (push_i && !doPop) begin
      wr_ptr_q <= nextIdx;
      if (!full_o) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  // Pop-and-push replaces the top entry in place, so the depth is unchanged.
  always_ff @(posedge clock) begin
    if (reset_n && push_i) begin
      if (doPop) begin
        mem_q[topIdx] <= data_i;
      end else begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

endmodule
`endif

// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN/HALTED sequencing, fetch handshake, redirects.
// Define PC_RAS_EN to add call/ret handling through the pc_ras return stack.
module pc_unit import pc_pkg::*; #(
  parameter int unsigned       ADDR_W      = PC_DEF_ADDR_W,
  parameter int unsigned       INSTR_BYTES = PC_DEF_INSTR_BYTES,
  parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(PC_DEF_RESET_VEC),
  parameter int unsigned       RAS_DEPTH   = PC_DEF_RAS_DEPTH
) (
  input logic      clock,
  input logic      reset_n,
  pc_unit_if.slave bus
);

  if (INSTR_BYTES == 0 || RAS_DEPTH == 0) begin : g_cfg_check
    $error("pc_unit: INSTR_BYTES and RAS_DEPTH must be non-zero");
  end

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pcNext;
  logic              pcValid;
  logic              accept;
  logic              retTaken;
  logic              rasPush;
  logic              rasPop;
  logic [ADDR_W-1:0] rasTop;

  assign pcNext = pc_q + ADDR_W'(INSTR_BYTES);
  assign accept = pcValid && bus.fetch_ready_i;

`ifdef PC_RAS_EN
  logic rasEmpty;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ras (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (rasPush),
    .pop_i   (rasPop),
    .data_i  (pcNext),
    .top_o   (rasTop),
    .empty_o (rasEmpty),
    .full_o  ()
  );

  assign retTaken        = bus.ret_i && accept && !rasEmpty;
  assign bus.ras_empty_o = rasEmpty;
`else
  assign retTaken = 1'b0;
  assign rasTop   = '0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Priority within RUN: redirect, then a ret that actually pops, then halt/sequential.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rasPush = 1'b0;
    rasPop  = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.redirect_i) begin
          pc_d = bus.redirect_addr_i;
`ifdef PC_RAS_EN
          rasPush = bus.call_i;
`endif
        end else if (retTaken) begin
          pc_d   = rasTop;
          rasPop = 1'b1;
`ifdef PC_RAS_EN
          rasPush = bus.call_i;
`endif
        end else begin
          if (accept) begin
            pc_d = pcNext;
`ifdef PC_RAS_EN
            rasPush = bus.call_i;
`endif
          end
          if (bus.halt_i) begin
            state_d = HALTED;
          end
        end
      end
      HALTED: begin
        if (bus.redirect_i) begin
          pc_d = bus.redirect_addr_i;
        end else if (bus.resume_i) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pcValid = (state_q == RUN);
  end

  assign bus.pc_o       = pc_q;
  assign bus.pc_valid_o = pcValid;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (ADDR_W=32, RESET_VEC=0x100); RAS checks need PC_RAS_EN.
module tb_pc_unit;
  import pc_pkg::*;

  localparam int unsigned ADDR_W = 32;

  logic clock;
  logic reset_n;
  int   checkCount;
  int   passCount;

  pc_unit_if #(.ADDR_W(ADDR_W)) pcIf ();

  pc_unit #(
    .ADDR_W      (ADDR_W),
    .INSTR_BYTES (4),
    .RESET_VEC   (32'h0000_0100),
    .RAS_DEPTH   (4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (pcIf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in and return 1 ns after the edge.
  task automatic applyStimulus(input logic redirect, input logic [ADDR_W-1:0] addr,
                               input logic ready, input logic halt, input logic resume,
                               input logic call, input logic ret);
    pcIf.redirect_i      = redirect;
    pcIf.redirect_addr_i = addr;
    pcIf.fetch_ready_i   = ready;
    pcIf.halt_i          = halt;
    pcIf.resume_i        = resume;
`ifdef PC_RAS_EN
    pcIf.call_i          = call;
    pcIf.ret_i           = ret;
`else
    if (call || ret) $display("[TB] note: call/ret ignored without PC_RAS_EN");
`endif
    @(posedge clock);
    #1;
  endtask

  task automatic checkPc(input string tag, input logic [ADDR_W-1:0] pc, input logic valid);
    checkOutput({tag, ".pc"}, 64'(pcIf.pc_o), 64'(pc));
    checkOutput({tag, ".valid"}, 64'(pcIf.pc_valid_o), 64'(valid));
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset_n    = 1'b0;
    applyStimulus(0, '0, 1, 0, 0, 0, 0);
    applyStimulus(0, '0, 1, 0, 0, 0, 0);
    checkPc("boot", 32'h100, 0);
`ifdef PC_RAS_EN
    checkOutput("reset.ras_empty", 64'(pcIf.ras_empty_o), 64'd1);
`endif

    // Reset release with fetch always ready
    reset_n = 1'b1;
    applyStimulus(0, '0, 1, 0, 0, 0, 0);
    checkPc("run0", 32'h100, 1);
    applyStimulus(0, '0, 1, 0, 0, 0, 0);
    checkPc("run1", 32'h104, 1);
    applyStimulus(0, '0, 1, 0, 0, 0, 0);
    checkPc("run2", 32'h108, 1);

    // Stall for three cycles at 0x200
    applyStimulus(1, 32'h200, 0, 0, 0, 0, 0);
    checkPc("redir200", 32'h200, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, '0, 0, 0, 0, 0, 0);
      checkPc("stall", 32'h200, 1);
    end
    applyStimulus(0, '0, 1, 0, 0, 0, 0);
    checkPc("unstall", 32'h204, 1);

    // Redirect wins over a not-ready fetch
    applyStimulus(1, 32'h4000, 0, 0, 0, 0, 0);
    checkPc("redir4000", 32'h4000, 1);

    // Halt together with accept advances once, then holds
    applyStimulus(1, 32'h300, 0, 0, 0, 0, 0);
    applyStimulus(0, '0, 1, 1, 0, 0, 0);
    checkPc("halt", 32'h304, 0);
    applyStimulus(0, '0, 1, 0, 0, 0, 0);
    applyStimulus(0, '0, 1, 0, 0, 0, 0);
    checkPc("halted.hold", 32'h304, 0);
    applyStimulus(0, '0, 0, 0, 1, 0, 0);
    checkPc("resume", 32'h304, 1);
    applyStimulus(0, '0, 0, 0, 0, 0, 0);
    checkPc("reissue", 32'h304, 1);

    // Halt without accept, then redirect while halted
    applyStimulus(0, '0, 0, 1, 0, 0, 0);
    checkPc("halt.noacc", 32'h304, 0);
    applyStimulus(1, 32'h601, 0, 0, 0, 0, 0);
    checkPc("halted.redir", 32'h601, 0);
    applyStimulus(0, '0, 0, 0, 1, 0, 0);
    checkPc("resume2", 32'h601, 1);

    // Wrap at the top of the address space
    applyStimulus(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    checkPc("top", 32'hFFFF_FFFC, 1);
    applyStimulus(0, '0, 1, 0, 0, 0, 0);
    checkPc("wrap", 32'h0, 1);
    applyStimulus(0, '0, 1, 0, 0, 0, 0);
    checkPc("wrap+4", 32'h4, 1);

`ifdef PC_RAS_EN
    // Five calls into a four-deep stack drop the oldest return address
    applyStimulus(1, 32'h10, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, ADDR_W'((i + 1) * 16), 1, 0, 0, 1, 0);
    end
    checkPc("calls", 32'h60, 1);
    checkOutput("calls.ras_empty", 64'(pcIf.ras_empty_o), 64'd0);
    applyStimulus(1, 32'h800, 1, 0, 0, 0, 1);
    checkPc("redir.ret", 32'h800, 1);
    applyStimulus(0, '0, 0, 0, 0, 0, 1);
    checkPc("ret.noacc", 32'h800, 1);
    applyStimulus(0, '0, 1, 0, 0, 0, 1);
    checkPc("ret1", 32'h54, 1);
    applyStimulus(0, '0, 1, 0, 0, 0, 1);
    checkPc("ret2", 32'h44, 1);
    applyStimulus(0, '0, 1, 0, 0, 0, 1);
    checkPc("ret3", 32'h34, 1);
    applyStimulus(0, '0, 1, 0, 0, 0, 1);
    checkPc("ret4", 32'h24, 1);
    checkOutput("ret4.ras_empty", 64'(pcIf.ras_empty_o), 64'd1);
    applyStimulus(0, '0, 1, 0, 0, 0, 1);
    checkPc("ret5", 32'h28, 1);
    checkOutput("ret5.ras_empty", 64'(pcIf.ras_empty_o), 64'd1);
    applyStimulus(0, '0, 1, 0, 0, 1, 0);
    checkOutput("call.ras_empty", 64'(pcIf.ras_empty_o), 64'd0);
`endif

    // Reset mid-run discards a pending redirect
    reset_n = 1'b0;
    applyStimulus(1, 32'h999, 1, 0, 0, 1, 1);
    checkPc("midreset", 32'h100, 0);
`ifdef PC_RAS_EN
    checkOutput("midreset.ras_empty", 64'(pcIf.ras_empty_o), 64'd1);
`endif
    reset_n = 1'b1;
    applyStimulus(0, '0, 1, 0, 0, 0, 0);
    checkPc("rerun", 32'h100, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_W, default 64, PC width in bits.
REQ-002 Parameter INSTR_BYTES, default 4, sequential increment step.
REQ-003 Parameter RESET_VEC, default 0, PC value loaded at reset.
REQ-004 Parameter RAS_DEPTH, default 4, return-stack entries, used only with PC_RAS_EN.
REQ-005 clock  input  1  single clock; all state updates on posedge.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 redirect_i  input  1  branch/jump redirect request.
REQ-008 redirect_addr_i  input  ADDR_W  redirect target.
REQ-009 fetch_ready_i  input  1  fetch stage accepts current PC.
REQ-010 halt_i  input  1  stop issuing PCs.
REQ-011 resume_i  input  1  leave HALTED.
REQ-012 call_i  input  1  push return address; present only with PC_RAS_EN.
REQ-013 ret_i  input  1  pop return address into PC; present only with PC_RAS_EN.
REQ-014 pc_o  output  ADDR_W  current PC, registered.
REQ-015 pc_valid_o  output  1  pc_o is valid for fetch.
REQ-016 ras_empty_o  output  1  return stack empty; present only with PC_RAS_EN.

Function
REQ-017 States SHALL be BOOT, RUN, HALTED; BOOT->RUN after one cycle, RUN->HALTED on halt_i, HALTED->RUN on resume_i.
REQ-018 In BOOT, pc_valid_o SHALL be 0 and pc_o SHALL equal RESET_VEC.
REQ-019 In RUN, pc_valid_o SHALL be 1; in HALTED, pc_valid_o SHALL be 0 and pc_o SHALL hold.
REQ-020 Handshake: PC is accepted when pc_valid_o && fetch_ready_i; on accept without other events, pc_o SHALL become pc_o+INSTR_BYTES next cycle.
REQ-021 When not accepted and no redirect, pc_o SHALL hold unchanged (stall).
REQ-022 redirect_i SHALL load redirect_addr_i next cycle in RUN or HALTED, regardless of fetch_ready_i; state is unchanged.
REQ-023 Priority, highest first: reset, redirect_i, ret_i, halt_i, sequential increment.
REQ-024 halt_i with accept in same cycle: pc_o SHALL advance once, then enter HALTED.
REQ-025 Arithmetic SHALL be modulo 2^ADDR_W; all-ones minus INSTR_BYTES+1 wraps to low addresses with no flag.
REQ-026 redirect_addr_i alignment SHALL NOT be checked; value loaded verbatim.

Reset
REQ-027 reset_n low at posedge SHALL set state BOOT, pc_o=RESET_VEC, pc_valid_o=0, return stack empty, ras_empty_o=1.
REQ-028 Reset mid-operation SHALL discard pending redirect, call and ret in that cycle.

Configuration
REQ-029 Macro PC_RAS_EN compiled in: return stack of RAS_DEPTH entries; call_i on accept pushes pc_o+INSTR_BYTES; ret_i on accept loads popped entry into pc_o.
REQ-030 call_i on full stack SHALL overwrite the oldest entry (circular); ret_i on empty stack SHALL be treated as sequential increment.
REQ-031 call_i and ret_i together SHALL pop into pc_o then push the new return address (net depth unchanged).
REQ-032 redirect_i with call_i SHALL load redirect_addr_i and push pc_o+INSTR_BYTES.
REQ-033 Without PC_RAS_EN: call_i, ret_i, ras_empty_o and stack storage SHALL be absent; behaviour per REQ-017..026 only.

Structure
REQ-034 Shared package pc_pkg SHALL hold the state enum (BOOT, RUN, HALTED) and default parameter constants.
REQ-035 Return stack SHALL be sub-module pc_ras (push, pop, top, empty, full), instantiated only under PC_RAS_EN.

Verification
REQ-036 Reset release, fetch_ready_i=1, RESET_VEC=0x100: pc_o 0x100 (BOOT, valid 0), then 0x100, 0x104, 0x108 with valid 1.
REQ-037 fetch_ready_i low 3 cycles at pc_o=0x200: pc_o holds 0x200; ready high: 0x204 next cycle.
REQ-038 redirect_i with 0x4000 while fetch_ready_i=0: pc_o=0x4000 next cycle; redirect plus ret_i same cycle: redirect wins.
REQ-039 halt_i at 0x300 with ready=1: pc_o=0x304, valid 0, holds; resume_i: valid 1, 0x304 reissued.
REQ-040 PC_RAS_EN, RAS_DEPTH=4: call at 0x10, 0x20, 0x30, 0x40, 0x50, then 4 rets yield 0x54, 0x44, 0x34, 0x24; fifth ret yields sequential increment, ras_empty_o=1.
REQ-041 ADDR_W=32, pc_o=0xFFFFFFFC accepted: pc_o=0x00000000; reset_n low mid-run: pc_o=RESET_VEC, valid 0 next cycle.
